apb_mem_slave: RTL and testbench

Parametrised APB completer with an internal register-file memory, configurable data/address width, depth and wait-state count, plus error response. Successor to the fixed 8-bit, 64-entry, zero-wait memory slave on the APB bus. Sits behind the APB master/decoder as one PSEL-selected completer. Adds registered read data, a clocked transfer state machine, wait-state insertion and PSLVERR for out-of-range addresses.

---
 rtl/apb_mem_slave_if.sv | 27 ++
 rtl/apb_mem_slave.sv | 128 ++++++++++++
 tb/tb_apb_mem_slave.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_slave_if.sv
// APB completer-side bus bundle for apb_mem_slave.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : driven by the requester/decoder
//   PRDATA/PREADY/PSLVERR            : driven by the completer
// The master modport is the requester's view; slave is the completer's view.
interface apb_mem_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_slave.sv
// Parametrised APB completer backed by a word-indexed register-file memory.
// A transfer is latched on the setup edge (address, direction, write data,
// range error); the access phase then inserts WAIT_STATES PREADY-low cycles
// before a single PREADY-high completion cycle. Out-of-range addresses
// complete with PSLVERR=1, never touch memory and read back as zero.
// Read data is fetched on the setup edge and held until the next read setup.
//
// Ports:
//   PCLK    : bus clock, all state changes on the rising edge
//   PRESETn : asynchronous active-low reset
//   bus     : apb_mem_slave_if slave modport (PSEL, PENABLE, PWRITE, PADDR,
//             PWDATA in; PRDATA, PREADY, PSLVERR out)
module apb_mem_slave #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_mem_slave_if.slave bus
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] prdata_q;

  logic              setup;     // setup phase accepted this edge
  logic              complete;  // access phase finishes this edge
  logic              commit;    // memory write happens this edge
  logic              in_range;
  logic [IDX_W-1:0]  req_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // Range check on the full address so values past DEPTH never alias
  // onto a low entry.
  assign in_range = (32'(bus.PADDR) < DEPTH);
  assign req_idx  = IDX_W'(bus.PADDR);

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    setup    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        // PSEL&PENABLE without a preceding setup is ignored here.
        if (bus.PSEL && !bus.PENABLE) begin
          setup   = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          // Requester abandoned the transfer: no write, PRDATA untouched.
          state_d = IDLE;
        end else if (bus.PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = complete && write_q && !err_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        idx_q   <= req_idx;
        write_q <= bus.PWRITE;
        wdata_q <= bus.PWDATA;
        err_q   <= !in_range;
        if (!bus.PWRITE) begin
          prdata_q <= in_range ? mem[req_idx] : '0;
        end
      end
    end
  end

  // NOTE: the storage array has no reset; contents are undefined until
  // written. A reset mid-transfer still blocks the write because commit
  // depends on state_q, which resets asynchronously to IDLE.
  always_ff @(posedge PCLK) begin
    if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // PREADY/PSLVERR come straight from registers, never from bus inputs.
  assign bus.PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign bus.PSLVERR = bus.PREADY && err_q;
  assign bus.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave. Two completers (WAIT_STATES 0 and 3)
// sit behind a one-hot decoder driven by a single requester. A transaction
// level model predicts PREADY/PSLVERR/PRDATA for both on every cycle; directed
// transfers additionally pin latency and data against hand-computed literals.
module tb_apb_mem_slave;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  // requester-side drive
  logic              psel    = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite  = 1'b0;
  logic [ADDR_W-1:0] paddr   = '0;
  logic [DATA_W-1:0] pwdata  = '0;
  int                tgt     = 0;

  apb_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  apb_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

  assign bus0.PSEL    = psel && (tgt == 0);
  assign bus0.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus3.PSEL    = psel && (tgt == 1);
  assign bus3.PENABLE = penable;
  assign bus3.PWRITE  = pwrite;
  assign bus3.PADDR   = paddr;
  assign bus3.PWDATA  = pwdata;

  apb_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus0.slave));
  apb_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus3.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic get_ready(input int d);
    return (d == 0) ? bus0.PREADY : bus3.PREADY;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? bus0.PSLVERR : bus3.PSLVERR;
  endfunction
  function automatic logic [DATA_W-1:0] get_rdata(input int d);
    return (d == 0) ? bus0.PRDATA : bus3.PRDATA;
  endfunction

  // ---------------- transaction-level model ----------------
  bit                busy      [2];
  int                waited    [2];  // access edges already spent waiting
  bit                m_wr      [2];
  bit                m_err     [2];
  int                m_addr    [2];
  logic [DATA_W-1:0] m_wdata   [2];
  logic [DATA_W-1:0] m_mem     [2][DEPTH];
  bit                m_memv    [2][DEPTH];
  logic [DATA_W-1:0] m_prd     [2];
  bit                m_prd_ok  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d]     = 1'b0;
      waited[d]   = 0;
      m_prd[d]    = '0;
      m_prd_ok[d] = 1'b1;
    end
  endtask

  // Applies the rules for one rising edge using the inputs both DUTs saw.
  task automatic model_update();
    if (!PRESETn) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      bit s;
      s = psel && (tgt == d);
      if (busy[d]) begin
        if (!s) begin
          busy[d] = 1'b0;
        end else if (penable) begin
          if (waited[d] == ws(d)) begin
            if (m_wr[d] && !m_err[d]) begin
              m_mem[d][m_addr[d]]  = m_wdata[d];
              m_memv[d][m_addr[d]] = 1'b1;
            end
            busy[d] = 1'b0;
          end else begin
            waited[d]++;
          end
        end
      end else if (s && !penable) begin
        busy[d]    = 1'b1;
        waited[d]  = 0;
        m_wr[d]    = pwrite;
        m_addr[d]  = int'(paddr);
        m_err[d]   = (int'(paddr) >= DEPTH);
        m_wdata[d] = pwdata;
        if (!pwrite) begin
          if (m_err[d]) begin
            m_prd[d]    = '0;
            m_prd_ok[d] = 1'b1;
          end else begin
            m_prd[d]    = m_mem[d][m_addr[d]];
            m_prd_ok[d] = m_memv[d][m_addr[d]];
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of both completers against the model.
  always @(negedge PCLK) begin
    for (int d = 0; d < 2; d++) begin
      logic exp_rdy;
      exp_rdy = busy[d] && (waited[d] == ws(d));
      check($sformatf("cyc dut%0d PREADY", d),  32'(get_ready(d)), 32'(exp_rdy));
      check($sformatf("cyc dut%0d PSLVERR", d), 32'(get_err(d)),   32'(exp_rdy && m_err[d]));
      if (m_prd_ok[d])
        check($sformatf("cyc dut%0d PRDATA", d), 32'(get_rdata(d)), 32'(m_prd[d]));
    end
  end

  // ---------------- requester ----------------
  task automatic step();
    @(posedge PCLK);
    model_update();
    @(negedge PCLK);
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) step();
  endtask

  // One transfer. abort_at >= 0 drops PSEL before that access iteration.
  task automatic xfer(input int t, input bit wr, input int addr, input logic [DATA_W-1:0] data,
                      input int abort_at, output bit done, output int lat,
                      output logic [DATA_W-1:0] rd_first, output logic [DATA_W-1:0] rdata,
                      output bit err);
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = ADDR_W'(addr); pwdata = data;
    step();
    penable  = 1'b1;
    done     = 1'b0;
    lat      = -1;
    rd_first = get_rdata(t);
    rdata    = '0;
    err      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == abort_at) begin
        psel = 1'b0; penable = 1'b0;
        step();
        return;
      end
      if (get_ready(t)) begin
        done = 1'b1; lat = i; rdata = get_rdata(t); err = get_err(t);
        step();
        return;
      end
      // address/data wiggle during access must be ignored
      paddr  = ADDR_W'($urandom);
      pwdata = DATA_W'($urandom);
      step();
    end
    check($sformatf("xfer timeout dut%0d", t), 32'd0, 32'd1);
  endtask

  initial begin
    bit                done, err;
    int                lat;
    logic [DATA_W-1:0] rf, rd;

    model_reset();
    PRESETn = 1'b0;
    repeat (2) step();
    check("reset dut0 PREADY",  32'(bus0.PREADY),  32'd0);
    check("reset dut0 PSLVERR", 32'(bus0.PSLVERR), 32'd0);
    check("reset dut0 PRDATA",  32'(bus0.PRDATA),  32'd0);
    check("reset dut3 PREADY",  32'(bus3.PREADY),  32'd0);
    PRESETn = 1'b1;
    idle(1);

    // zero-wait write then read
    xfer(0, 1'b1, 5, 8'h3C, -1, done, lat, rf, rd, err);
    check("w5 latency", 32'(lat), 32'd0);
    check("w5 pslverr", 32'(err), 32'd0);
    xfer(0, 1'b0, 5, 8'h00, -1, done, lat, rf, rd, err);
    check("r5 latency", 32'(lat), 32'd0);
    check("r5 data",    32'(rd),  32'h3C);
    check("r5 pslverr", 32'(err), 32'd0);

    // three wait states
    xfer(1, 1'b1, 0, 8'h11, -1, done, lat, rf, rd, err);
    check("ws3 w0 latency", 32'(lat), 32'd3);
    xfer(1, 1'b0, 0, 8'h00, -1, done, lat, rf, rd, err);
    check("ws3 r0 latency",    32'(lat), 32'd3);
    check("ws3 r0 early data", 32'(rf),  32'h11);
    check("ws3 r0 data",       32'(rd),  32'h11);

    // out-of-range, no wrap-around
    xfer(0, 1'b1, 0, 8'h00, -1, done, lat, rf, rd, err);
    xfer(0, 1'b1, 64, 8'hFF, -1, done, lat, rf, rd, err);
    check("w64 done",    32'(done), 32'd1);
    check("w64 pslverr", 32'(err),  32'd1);
    xfer(0, 1'b0, 200, 8'h00, -1, done, lat, rf, rd, err);
    check("r200 pslverr", 32'(err), 32'd1);
    check("r200 data",    32'(rd),  32'h00);
    xfer(0, 1'b0, 0, 8'h00, -1, done, lat, rf, rd, err);
    check("r0 after w64 data",    32'(rd),  32'h00);
    check("r0 after w64 pslverr", 32'(err), 32'd0);

    // back-to-back writes incl. last valid entry
    xfer(0, 1'b1, 1, 8'hA1, -1, done, lat, rf, rd, err);
    xfer(0, 1'b1, 2, 8'hA2, -1, done, lat, rf, rd, err);
    xfer(0, 1'b1, 3, 8'hA3, -1, done, lat, rf, rd, err);
    xfer(0, 1'b1, 63, 8'h63, -1, done, lat, rf, rd, err);
    check("w63 pslverr", 32'(err), 32'd0);
    xfer(0, 1'b0, 1, 8'h00, -1, done, lat, rf, rd, err);
    check("r1 data", 32'(rd), 32'hA1);
    xfer(0, 1'b0, 2, 8'h00, -1, done, lat, rf, rd, err);
    check("r2 data", 32'(rd), 32'hA2);
    xfer(0, 1'b0, 3, 8'h00, -1, done, lat, rf, rd, err);
    check("r3 data", 32'(rd), 32'hA3);
    xfer(0, 1'b0, 63, 8'h00, -1, done, lat, rf, rd, err);
    check("r63 data", 32'(rd), 32'h63);

    // master abort and access without setup
    xfer(1, 1'b1, 9, 8'h42, -1, done, lat, rf, rd, err);
    xfer(1, 1'b1, 9, 8'h77, 1, done, lat, rf, rd, err);
    check("abort no completion", 32'(done), 32'd0);
    idle(1);
    tgt = 1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd9; pwdata = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no-setup PREADY", 32'(bus3.PREADY), 32'd0);
    end
    idle(1);
    xfer(1, 1'b0, 9, 8'h00, -1, done, lat, rf, rd, err);
    check("r9 after abort", 32'(rd), 32'h42);

    // asynchronous reset mid-access (cnt=2)
    xfer(1, 1'b1, 12, 8'h5A, -1, done, lat, rf, rd, err);
    xfer(1, 1'b0, 0, 8'h00, -1, done, lat, rf, rd, err);
    tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd12; pwdata = 8'hA5;
    step();
    penable = 1'b1;
    step();
    #2 PRESETn = 1'b0;
    model_reset();
    #1;
    check("async rst PREADY",  32'(bus3.PREADY),  32'd0);
    check("async rst PSLVERR", 32'(bus3.PSLVERR), 32'd0);
    check("async rst PRDATA",  32'(bus3.PRDATA),  32'd0);
    psel = 1'b0; penable = 1'b0;
    step();
    PRESETn = 1'b1;
    idle(1);
    xfer(1, 1'b0, 12, 8'h00, -1, done, lat, rf, rd, err);
    check("r12 after reset", 32'(rd), 32'h5A);
    check("r12 latency",     32'(lat), 32'd3);

    // randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      int t, a, ab;
      t  = int'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(64, 255)) : int'($urandom_range(0, 63));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ws(t))) : -1;
      xfer(t, 1'($urandom), a, DATA_W'($urandom), ab, done, lat, rf, rd, err);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
